// File: rtl/g15_seq_pkg.sv
// Shared types and constants for the G-15 command sequencer.
package g15_seq_pkg;

  localparam int G15_WORDS = 108;

  typedef logic [6:0] pos_t;

  typedef enum logic [2:0] {
    HALT     = 3'd0,
    WAIT_CMD = 3'd1,
    READ     = 3'd2,
    WAIT_T   = 3'd3,
    XFER     = 3'd4,
    WAIT_RDY = 3'd5
  } seq_state_t;

endpackage

// File: rtl/drum_pos_counter.sv
// Drum angular position counter: advances once per word time, wraps modulo
// WORDS, and snaps to zero on the origin marker.
module drum_pos_counter
  import g15_seq_pkg::*;
#(
  parameter int WORDS = G15_WORDS,
  parameter int PW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          t29_i,
  input  logic          word0_i,
  output logic [PW-1:0] pos_o,
  output logic [PW-1:0] nxt_o
);

  logic [PW-1:0] pos_q, pos_d;

  always_comb begin
    if (word0_i) begin
      nxt_o = '0;
    end else if (pos_q == PW'(WORDS - 1)) begin
      nxt_o = '0;
    end else begin
      nxt_o = pos_q + PW'(1);
    end
    pos_d = t29_i ? nxt_o : pos_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Word-time sequencer for the G-15 CPU: read-command, wait and transfer
// phases keyed to drum position, with GO / NO-GO / breakpoint halting.
module cmd_sequencer
  import g15_seq_pkg::*;
#(
  parameter int WORDS = G15_WORDS,
  parameter int PW    = 7
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          T29,
  input  logic          WORD0,
  input  logic          SW_GO,
  input  logic          SW_NO_GO,
  input  logic          SW_BP,
  input  logic          READY,
  input  logic [PW-1:0] CMD_T,
  input  logic [PW-1:0] CMD_N,
  input  logic          CMD_DEF,
  input  logic          CMD_BP,
  input  logic          CMD_WAIT_RDY,
  output logic          RC,
  output logic          CMD_LOAD,
  output logic          TR,
  output logic          HALTED,
  output logic [PW-1:0] POS,
  output logic [2:0]    STATE
);

  logic [PW-1:0] pos, nxt;
  seq_state_t    state_q, state_d;
  logic [PW-1:0] t_q, t_d, n_q, n_d;
  logic          def_q, def_d, bp_q, bp_d, wrdy_q, wrdy_d;
  logic          halt_req, xfer_done;
  seq_state_t    resume_st;

  drum_pos_counter #(.WORDS(WORDS), .PW(PW)) u_pos (
    .clk_i  (CLOCK),
    .rst_ni (rst),
    .t29_i  (T29),
    .word0_i(WORD0),
    .pos_o  (pos),
    .nxt_o  (nxt)
  );

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state_q <= HALT;
      t_q     <= '0;
      n_q     <= '0;
      def_q   <= 1'b0;
      bp_q    <= 1'b0;
      wrdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      def_q   <= def_d;
      bp_q    <= bp_d;
      wrdy_q  <= wrdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    n_d       = n_q;
    def_d     = def_q;
    bp_d      = bp_q;
    wrdy_d    = wrdy_q;
    halt_req  = SW_NO_GO | (bp_q & SW_BP);
    resume_st = halt_req ? HALT : ((nxt == n_q) ? READ : WAIT_CMD);
    // A deferred transfer is always a single word, even if WORD0 re-bases POS.
    xfer_done = def_q | (pos == t_q);
    if (T29) begin
      case (state_q)
        HALT:     if (SW_GO && !SW_NO_GO) state_d = WAIT_CMD;
        WAIT_CMD: if (nxt == n_q) state_d = READ;
        READ: begin
          t_d    = CMD_T;
          n_d    = CMD_N;
          def_d  = CMD_DEF;
          bp_d   = CMD_BP;
          wrdy_d = CMD_WAIT_RDY;
          state_d = (!CMD_DEF || nxt == CMD_T) ? XFER : WAIT_T;
        end
        WAIT_T:   if (nxt == t_q) state_d = XFER;
        XFER: begin
          if (xfer_done) state_d = (!halt_req && wrdy_q) ? WAIT_RDY : resume_st;
        end
        WAIT_RDY: if (READY) state_d = resume_st;
        default:  state_d = HALT;
      endcase
    end
  end

  assign RC       = (state_q == WAIT_CMD) || (state_q == READ);
  assign CMD_LOAD = (state_q == READ);
  assign TR       = (state_q == XFER);
  assign HALTED   = (state_q == HALT);
  assign POS      = pos;
  assign STATE    = state_q;

endmodule
